muldiv_unit: RTL

Execute-stage multi-cycle multiply/divide engine that consumes the 5-bit ALU control code produced by the ALU decoder.
- Acts on the MULT, MULTU, DIV and DIVU codes only; every other code is ignored.
- Returns a 64-bit {hi, lo} result with a one-cycle done pulse.
- Raises a stall so the pipeline holds the instruction in EX until the result is ready.
- The HI/LO register file sits downstream and writes on done.

---
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine for the EX stage; returns {hi, lo} with a one-cycle done pulse.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier for MULT/MULTU (divide is unchanged).
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alucontrol,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  state_dbg
);

  localparam logic [4:0] MULT_CONTROL  = 5'b10000;
  localparam logic [4:0] MULTU_CONTROL = 5'b10001;
  localparam logic [4:0] DIV_CONTROL   = 5'b10010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b10011;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL_RUN = 2'd1, DIV_RUN = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] divisor;
  logic        neg_res;
  logic        neg_rem;

  logic        is_mul;
  logic        is_div;
  logic        op_signed;
  logic        accept;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] acc_next;
  logic [63:0] mul_final;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] rem_new;
  logic [31:0] quo_new;
  logic [31:0] quo_final;
  logic [31:0] rem_final;
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  logic [63:0] fast_result;
`endif

  // Handshake: an op is taken when start=1, flush=0, state IDLE and the code is a mul/div
  // code; stall then stays high until the cycle before done, which pulses for exactly one cycle.
  always_comb begin
    is_mul    = (alucontrol == MULT_CONTROL) || (alucontrol == MULTU_CONTROL);
    is_div    = (alucontrol == DIV_CONTROL)  || (alucontrol == DIVU_CONTROL);
    op_signed = (alucontrol == MULT_CONTROL) || (alucontrol == DIV_CONTROL);
    accept    = start && !flush && (state == IDLE) && (is_mul || is_div);
    abs_a     = (op_signed && a[31]) ? (~a + 32'd1) : a;
    abs_b     = (op_signed && b[31]) ? (~b + 32'd1) : b;
    stall     = accept || (state == MUL_RUN) || (state == DIV_RUN);
    state_dbg = state;
  end

  always_comb begin
    acc_next  = acc + (mplier[0] ? mcand : 64'd0);
    mul_final = neg_res ? (~acc_next + 64'd1) : acc_next;
  end

  // Restoring step: shift in the next dividend bit, keep the difference only when non-negative.
  always_comb begin
    rem_shift = {rem, quo[31]};
    diff      = rem_shift - {1'b0, divisor};
    ge        = !diff[32];
    rem_new   = ge ? diff[31:0] : rem_shift[31:0];
    quo_new   = {quo[30:0], ge};
    quo_final = neg_res ? (~quo_new + 32'd1) : quo_new;
    rem_final = neg_rem ? (~rem_new + 32'd1) : rem_new;
  end

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    fast_prod   = {32'd0, abs_a} * {32'd0, abs_b};
    fast_result = (op_signed && (a[31] ^ b[31])) ? (~fast_prod + 64'd1) : fast_prod;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      done    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      acc     <= 64'd0;
      mcand   <= 64'd0;
      mplier  <= 32'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      divisor <= 32'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              neg_res <= op_signed && (a[31] ^ b[31]);
              neg_rem <= op_signed && a[31];
              cnt     <= 5'd0;
              if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                state    <= DONE;
                done     <= 1'b1;
                {hi, lo} <= fast_result;
`else
                acc    <= 64'd0;
                mcand  <= {32'd0, abs_a};
                mplier <= abs_b;
                state  <= MUL_RUN;
`endif
              end else if (b == 32'd0) begin
                state <= DONE;
                done  <= 1'b1;
                hi    <= a;
                lo    <= 32'hFFFF_FFFF;
              end else begin
                rem     <= 32'd0;
                quo     <= abs_a;
                divisor <= abs_b;
                state   <= DIV_RUN;
              end
            end
          end
          MUL_RUN: begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state    <= DONE;
              done     <= 1'b1;
              {hi, lo} <= mul_final;
            end
          end
          DIV_RUN: begin
            rem <= rem_new;
            quo <= quo_new;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state <= DONE;
              done  <= 1'b1;
              hi    <= rem_final;
              lo    <= quo_final;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
